conv_arbiter_rr: RTL and testbench
==================================

// Module: conv_arbiter_rr
// PURPOSE
//  Round-robin arbiter/sequencer sharing one offset-binary <-> two's-complement conversion datapath
//  between NUM_REQ streaming requesters (ADC capture, DAC playback, etc.). It grants one requester,
//  latches its sample, converts it (MSB inversion, i.e. +/-2^(WIDTH-1) mod 2^WIDTH), then holds the
//  result on a single valid/ready output tagged with the requester id. Sits between sample sources and the FFT/DAC logic.
// PARAMETERS
//  WIDTH    16  sample width in bits
//  NUM_REQ  2   number of requesters (2..8)
//  ID_W     3   width of out_id; must satisfy 2^ID_W >= NUM_REQ
// PORTS
//  clk            in   1              system clock, all logic rising-edge
//  rst            in   1              asynchronous, active-high reset
//  req_valid      in   NUM_REQ        per-requester sample valid
//  req_data       in   NUM_REQ*WIDTH  flattened samples, requester i at [i*WIDTH +: WIDTH]
//  req_is_signed  in   NUM_REQ        1: sample is two's-comp -> emit offset-binary; 0: reverse
//  req_ready      out  NUM_REQ        one-hot accept strobe, sample taken when valid&ready
//  out_valid      out  1              converted sample available
//  out_data       out  WIDTH          converted sample
//  out_id         out  ID_W           index of requester that produced out_data
//  out_ready      in   1              downstream accept
//  busy           out  1              high whenever FSM not in IDLE
// BEHAVIOUR
//  Reset: req_ready=0, out_valid=0, out_data=0, out_id=0, busy=0, FSM=IDLE, rr pointer=0.
//  FSM: IDLE -> GRANT -> CONV -> HOLD -> IDLE (or GRANT directly, see below).
//  IDLE: if any req_valid, pick first valid index at or after rr pointer (wrapping NUM_REQ-1 -> 0),
//   register grant index; go GRANT. No valid -> stay IDLE.
//  GRANT: assert req_ready[g] for exactly this one cycle; latch req_data slice and req_is_signed of g.
//   If req_valid[g] has dropped this cycle, no transfer: return to IDLE, rr pointer unchanged.
//  CONV: out_data <= latched ^ (1<<(WIDTH-1)) (identical for both directions, mod 2^WIDTH);
//   out_id <= g; out_valid <= 1; rr pointer <= (g+1) wrapping at NUM_REQ; go HOLD.
//  HOLD: out_valid, out_data, out_id stable until out_valid&out_ready. On that cycle out_valid<=0;
//   if any req_valid present, arbitrate immediately (same rule, updated pointer) and go GRANT, else IDLE.
//  Latency: req_ready pulse to out_valid = 2 cycles; best-case throughput 1 sample / 3 cycles.
//  req_ready is never asserted while out_valid=1 (single-entry buffering, no overwrite).
//  Boundary values: 0x8000 signed -> 0x0000; 0x7FFF signed -> 0xFFFF; 0x0000 unsigned -> 0x8000;
//   0xFFFF unsigned -> 0x7FFF (WIDTH=16).
//  Pointer wrap: grant of NUM_REQ-1 sets pointer to 0. Only one requester valid -> it is granted every time.
//  Simultaneous: all valid -> strict rotation 0,1,...,NUM_REQ-1,0.
//  Reset mid-operation: all state cleared asynchronously; any held output is discarded, no req_ready pulse.
// CONFIGURATION
//  CONV_ARB_STATS_EN defined: adds output ports xfer_count [NUM_REQ*16] (per-requester
//   completed-transfer counters, increment on out_valid&out_ready for out_id, saturate at 0xFFFF,
//   cleared by rst) and stall_flag [1] (sticky, set when out_valid held >255 consecutive cycles, cleared by rst).
//  Not defined: those ports and counters are absent; all other behaviour identical.
// TESTING
//  Reset: assert rst mid-HOLD with out_valid=1 -> out_valid,req_ready,busy drop immediately, out_data=0.
//  Single req0, data=0x8000 signed, out_ready=1 -> req_ready[0] one cycle, 2 cycles later out_data=0x0000, out_id=0.
//  req0 unsigned 0xFFFF -> 0x7FFF; req1 signed 0x7FFF -> 0xFFFF; both valid continuously -> ids alternate 0,1,0,1.
//  NUM_REQ=4 all valid, pointer at 3 -> grant order 3,0,1,2 (wrap checked).
//  out_ready held 0 for 20 cycles -> out_data/out_id stable, no req_ready pulses; release -> next grant same cycle.
//  req_valid[1] withdrawn in GRANT cycle -> no output, FSM back to IDLE, next grant still starts at 1.
//  With CONV_ARB_STATS_EN: 3 transfers from req1 -> xfer_count[1]=3; hold out_ready=0 300 cycles -> stall_flag=1.

Source files
------------

// File: rtl/conv_arbiter_rr.sv
// conv_arbiter_rr: round-robin sharing of one offset-binary <-> two's-complement converter.
// Optional feature macro CONV_ARB_STATS_EN adds per-requester transfer counters and a stall flag.
module conv_arbiter_rr #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_is_signed,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
`ifdef CONV_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]    xfer_count,
  output logic                     stall_flag,
`endif
  output logic                     busy
);

  localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_CONV,
    S_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [ID_W-1:0]      out_id_q, out_id_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     sample_q, sample_d;
  logic                 sgn_q, sgn_d;

  logic                 arb_found;
  logic [ID_W-1:0]      arb_idx;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic                 g_valid;
  logic [WIDTH-1:0]     g_data;
  logic                 g_sgn;
  logic [WIDTH-1:0]     conv_val;
  logic [ID_W-1:0]      ptr_next;

  function automatic int unsigned rot_idx(input logic [ID_W-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!arb_found && req_valid[j] && (j == rot_idx(ptr_q, i))) begin
          arb_found = 1'b1;
          arb_idx   = ID_W'(j);
        end
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      arb_onehot[j] = (32'(arb_idx) == j);
    end
  end

  // Mux out the currently granted requester's lane.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_sgn   = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (32'(grant_q) == j) begin
        g_valid = req_valid[j];
        g_data  = req_data[j*WIDTH +: WIDTH];
        g_sgn   = req_is_signed[j];
      end
    end
  end

  // Both directions reduce to flipping the MSB modulo 2^WIDTH.
  assign conv_val = sgn_q ? (sample_q + HALF) : (sample_q - HALF);
  assign ptr_next = (grant_q == LAST_ID) ? '0 : (grant_q + ID_W'(1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    sample_d    = sample_q;
    sgn_d       = sgn_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d     = arb_idx;
          req_ready_d = arb_onehot;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (g_valid) begin
          sample_d = g_data;
          sgn_d    = g_sgn;
          state_d  = S_CONV;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CONV: begin
        out_data_d  = conv_val;
        out_id_d    = grant_q;
        out_valid_d = 1'b1;
        ptr_d       = ptr_next;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (arb_found) begin
            grant_d     = arb_idx;
            req_ready_d = arb_onehot;
            state_d     = S_GRANT;
          end else begin
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      busy_q      <= 1'b0;
      sample_q    <= '0;
      sgn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      busy_q      <= busy_d;
      sample_q    <= sample_d;
      sgn_q       <= sgn_d;
    end
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;

`ifdef CONV_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] xfer_q, xfer_d;
  logic [8:0]            stall_cnt_q, stall_cnt_d;
  logic                  stall_q, stall_d;

  // Saturating per-id transfer counters; stall counter tracks consecutive out_valid cycles.
  always_comb begin
    xfer_d = xfer_q;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (out_valid_q && out_ready && (32'(out_id_q) == j) &&
          (xfer_q[j*16 +: 16] != 16'hFFFF)) begin
        xfer_d[j*16 +: 16] = xfer_q[j*16 +: 16] + 16'd1;
      end
    end
    if (!out_valid_q) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q == 9'h1FF) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + 9'd1;
    end
    stall_d = stall_q | (out_valid_q && (stall_cnt_q >= 9'd255));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_q      <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      xfer_q      <= xfer_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign xfer_count = xfer_q;
  assign stall_flag = stall_q;
`endif

endmodule

// File: tb/tb_conv_arbiter_rr.sv
// Self-checking bench for conv_arbiter_rr (NUM_REQ=4): vector table plus multi-cycle sequences.
module tb_conv_arbiter_rr;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_is_signed;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready;
  logic                     busy;
`ifdef CONV_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]    xfer_count;
  logic                     stall_flag;
`endif

  conv_arbiter_rr #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_is_signed(req_is_signed), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
`ifdef CONV_ARB_STATS_EN
    .xfer_count(xfer_count), .stall_flag(stall_flag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [15:0] din;
    logic        sgn;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;

  always @(negedge clk) begin
    if (!rst && out_valid && (|req_ready)) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned idx, input logic v, input logic [15:0] d, input logic s);
    req_valid[idx]                 = v;
    req_data[idx*WIDTH +: WIDTH]   = d;
    req_is_signed[idx]             = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int unsigned idx, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (req_ready[idx]) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 32'(req_ready), 32'(1) << idx);
  endtask

  // One isolated transfer with exact timing checks.
  task automatic do_vec(input vec_t v);
    bit ok;
    set_req(v.idx, 1'b1, v.din, v.sgn);
    out_ready = 1'b1;
    wait_ready(v.idx, "vec_ready", ok);
    if (ok) begin
      check("vec_ready_onehot", 32'(req_ready), 32'(1) << v.idx);
      check("vec_busy_grant", 32'(busy), 32'd1);
      tick();
      set_req(v.idx, 1'b0, v.din, v.sgn);
      check("vec_ready_pulse_end", 32'(req_ready), 32'd0);
      check("vec_no_early_valid", 32'(out_valid), 32'd0);
      tick();
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_out_data", 32'(out_data), 32'(v.exp));
      check("vec_out_id", 32'(out_id), v.idx);
      tick();
      check("vec_valid_drop", 32'(out_valid), 32'd0);
      check("vec_busy_idle", 32'(busy), 32'd0);
    end else begin
      set_req(v.idx, 1'b0, v.din, v.sgn);
    end
  endtask

  // Collect the ids of the next n outputs with out_ready held high.
  task automatic collect(input int n, input string name, output logic [2:0] ids[4],
                         output logic [15:0] dat[4]);
    int got = 0;
    for (int c = 0; c < 80 && got < n; c++) begin
      tick();
      if (out_valid) begin
        ids[got] = out_id;
        dat[got] = out_data;
        got++;
      end
    end
    if (got != n) check({name, "_timeout"}, 32'(got), 32'(n));
  endtask

  initial begin
    logic [2:0]  ids[4];
    logic [15:0] dat[4];
    logic [2:0]  exp_wrap[4];
    bit          ok;
    int          hold_bad;

    vecs[0] = '{0, 16'h8000, 1'b1, 16'h0000};
    vecs[1] = '{0, 16'hFFFF, 1'b0, 16'h7FFF};
    vecs[2] = '{1, 16'h7FFF, 1'b1, 16'hFFFF};
    vecs[3] = '{1, 16'h0000, 1'b0, 16'h8000};
    vecs[4] = '{2, 16'h1234, 1'b1, 16'h9234};
    vecs[5] = '{3, 16'hABCD, 1'b0, 16'h2BCD};
    exp_wrap = '{3'd3, 3'd0, 3'd1, 3'd2};

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_is_signed = '0;
    out_ready = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    do_reset();

    for (int k = 0; k < 6; k++) do_vec(vecs[k]);

    // Both 0 and 1 valid continuously: strict alternation from pointer 0.
    do_reset();
    set_req(0, 1'b1, 16'h0001, 1'b1);
    set_req(1, 1'b1, 16'h8002, 1'b0);
    collect(4, "alt", ids, dat);
    for (int k = 0; k < 4; k++) begin
      check("alt_id", 32'(ids[k]), 32'(k % 2));
      check("alt_data", 32'(dat[k]), (k % 2 == 0) ? 32'h8001 : 32'h0002);
    end
    req_valid = '0;

    // Pointer parked at 3, then all valid: 3,0,1,2.
    do_reset();
    do_vec(vecs[4]);
    for (int j = 0; j < 4; j++) set_req(j, 1'b1, 16'(j), 1'b1);
    collect(4, "wrap", ids, dat);
    for (int k = 0; k < 4; k++) check("wrap_id", 32'(ids[k]), 32'(exp_wrap[k]));
    req_valid = '0;

    // Downstream stall with a competing requester waiting.
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1'b1, 16'h1111, 1'b1);
    wait_ready(0, "stall_ready", ok);
    tick();
    set_req(0, 1'b0, 16'h1111, 1'b1);
    set_req(1, 1'b1, 16'h2222, 1'b0);
    tick();
    check("stall_out_valid", 32'(out_valid), 32'd1);
    hold_bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 16'h9111 || out_id !== 3'd0 || req_ready !== 4'd0)
        hold_bad++;
    end
    check("stall_hold_stable", 32'(hold_bad), 32'd0);
    out_ready = 1'b1;
    tick();
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_grant", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 16'h2222, 1'b0);
    tick();
    check("stall_next_id", 32'(out_id), 32'd1);
    check("stall_next_data", 32'(out_data), 32'hA222);
    tick();

    // Requester 1 withdraws during its GRANT cycle.
    do_reset();
    do_vec(vecs[0]);
    set_req(1, 1'b1, 16'h5555, 1'b1);
    wait_ready(1, "wd_ready", ok);
    set_req(1, 1'b0, 16'h5555, 1'b1);
    tick();
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_ready_clear", 32'(req_ready), 32'd0);
    hold_bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid !== 1'b0) hold_bad++;
    end
    check("wd_no_output", 32'(hold_bad), 32'd0);
    for (int j = 0; j < 4; j++) set_req(j, 1'b1, 16'(j), 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      if (|req_ready) ok = 1'b1;
    end
    check("wd_next_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check("wd_next_id", 32'(out_id), 32'd1);
    tick();

    // Asynchronous reset while holding an output.
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1'b1, 16'h1234, 1'b0);
    wait_ready(0, "mrst_ready", ok);
    tick();
    set_req(0, 1'b0, 16'h1234, 1'b0);
    tick();
    check("mrst_pre_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_req_ready", 32'(req_ready), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_out_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef CONV_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) do_vec(vecs[2]);
    check("stats_xfer1", 32'(xfer_count[16 +: 16]), 32'd3);
    check("stats_xfer0", 32'(xfer_count[0 +: 16]), 32'd0);
    check("stats_no_stall", 32'(stall_flag), 32'd0);
    out_ready = 1'b0;
    set_req(0, 1'b1, 16'h0F0F, 1'b1);
    wait_ready(0, "stats_ready", ok);
    tick();
    set_req(0, 1'b0, 16'h0F0F, 1'b1);
    for (int c = 0; c < 300; c++) tick();
    check("stats_stall_flag", 32'(stall_flag), 32'd1);
    do_reset();
    check("stats_stall_clear", 32'(stall_flag), 32'd0);
`endif

    check("no_ready_while_valid", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
